// File: rtl/stream_word_source.sv
// Valid/ready word transmitter: host writes fill a small FIFO whose contents are
// replayed on stream_out_*, with an optional idle gap after every accepted word.
module stream_word_source #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int GAP_CYCLES = 0,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  output logic                       stream_out_valid,
  input  logic                       stream_out_ready,
  output logic [DATA_WIDTH-1:0]      stream_out_data,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic [CNT_WIDTH-1:0]       words_sent,
  output logic [CNT_WIDTH-1:0]       stall_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [LW-1:0]         wr_ptr;
  logic [LW-1:0]         rd_ptr;
  logic [1:0]            state;
  logic [GW-1:0]         gap_cnt;
  logic                  fifo_empty;
  logic                  wr_en;
  logic                  pop;
  logic                  handshake;

  // Pointers carry one extra wrap bit so their difference is the occupancy.
  assign fifo_level       = wr_ptr - rd_ptr;
  assign wr_ready         = (fifo_level != LW'(DEPTH));
  assign fifo_empty       = (fifo_level == '0);
  assign wr_en            = wr_valid && wr_ready;
  assign stream_out_valid = (state == SEND);
  assign handshake        = (state == SEND) && stream_out_ready;

  always_comb begin
    pop = 1'b0;
    if (enable && !fifo_empty) begin
      case (state)
        IDLE:    pop = 1'b1;
        SEND:    pop = handshake && (GAP_CYCLES == 0);
        GAP:     pop = (gap_cnt == GW'(1));
        default: pop = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      state           <= IDLE;
      gap_cnt         <= '0;
      stream_out_data <= '0;
      words_sent      <= '0;
      stall_count     <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        stream_out_data <= mem[rd_ptr[AW-1:0]];
        rd_ptr          <= rd_ptr + 1'b1;
      end
      if (handshake) begin
        words_sent <= words_sent + 1'b1;
      end
      if ((state == SEND) && !stream_out_ready && (stall_count != '1)) begin
        stall_count <= stall_count + 1'b1;
      end

      // The offered word stays put until accepted, regardless of enable.
      case (state)
        IDLE: begin
          if (pop) begin
            state <= SEND;
          end
        end
        SEND: begin
          if (handshake) begin
            if (GAP_CYCLES > 0) begin
              state   <= GAP;
              gap_cnt <= GW'(GAP_CYCLES);
            end else if (!pop) begin
              state <= IDLE;
            end
          end
        end
        GAP: begin
          if (gap_cnt == GW'(1)) begin
            state <= pop ? SEND : IDLE;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/stream_word_source.md
Name: stream_word_source

Overview:
- Transmitter end of the 8-bit valid/ready byte stream consumed by the sample DUT's `stream_in_*` port group.
- A host (cocotb driver or upstream logic) pushes words through a simple write port into an internal FIFO.
- The block replays those words on a `stream_out_*` valid/ready interface, honouring backpressure, with an optional programmable inter-word gap.
- Counters expose delivered-word and stall statistics so benches can check throughput and backpressure.

Parameters:
- DATA_WIDTH, 8, width of each stream word.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- GAP_CYCLES, 0, idle cycles forced after each accepted word; 0 = back-to-back.
- CNT_WIDTH, 16, width of the statistics counters.

Ports:
- clk  in  1  sole clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  permits loading new words onto the stream.
- wr_valid  in  1  host write request.
- wr_ready  out  1  FIFO can accept a write; equals !full.
- wr_data  in  DATA_WIDTH  word to enqueue.
- stream_out_valid  out  1  output word valid.
- stream_out_ready  in  1  sink accepts word.
- stream_out_data  out  DATA_WIDTH  output word, registered.
- fifo_level  out  $clog2(DEPTH)+1  FIFO occupancy; excludes the word held in the output register.
- words_sent  out  CNT_WIDTH  count of completed handshakes; wraps.
- stall_count  out  CNT_WIDTH  cycles with valid=1 and ready=0; saturates at all-ones.

Behaviour:
- Reset (rst sampled high at an edge), effective after that edge:
  - stream_out_valid=0, stream_out_data=0, fifo_level=0, wr_ready=1, words_sent=0, stall_count=0.
  - FSM goes to IDLE; FIFO pointers and gap counter are cleared.
  - Reset has priority over all other events.
  - Reset mid-transfer discards the held word and all FIFO contents; no handshake is counted on the reset edge.
- FIFO write: a write occurs at an edge when wr_valid && wr_ready. There is no bypass path; every word passes through the FIFO.
- Full condition:
  - wr_ready = (fifo_level != DEPTH), computed from current state only.
  - A pop in the same cycle does not admit a write when full.
- Simultaneous write and pop: level is unchanged; data ordering is strictly FIFO.
- FSM states and transitions:
  - IDLE: valid=0. If enable && fifo_level>0 at an edge, pop the head into stream_out_data and go to SEND.
  - SEND: valid=1. stream_out_data and valid are held stable until the handshake (valid && ready at an edge). Deasserting enable never withdraws an offered word.
  - SEND on handshake: increment words_sent.
    - If GAP_CYCLES>0: load the gap counter with GAP_CYCLES and go to GAP.
    - Else if enable && FIFO non-empty: pop the next word and stay in SEND, giving one word per cycle.
    - Else go to IDLE.
  - GAP: valid=0; decrement the counter each cycle.
    - On the edge where the counter reads 1: if enable && FIFO non-empty, pop into SEND; else go to IDLE.
    - The gap is exactly GAP_CYCLES cycles of valid=0.
- Latency: a word written into an empty FIFO at edge k, with IDLE and enable=1, gives stream_out_valid=1 after edge k+1.
- stall_count: increments on each edge where valid=1 and ready=0. It holds at 2^CNT_WIDTH-1 once reached.
- words_sent: wraps from 2^CNT_WIDTH-1 to 0.
- Empty boundary: in SEND with an empty FIFO, a handshake returns the FSM to IDLE with valid=0 the next cycle. No bubble word is emitted.
- Back-to-back throughput (GAP_CYCLES=0, ready=1, FIFO kept fed): one word per clock.

Test Plan:
- Reset state: assert rst for 2 cycles with wr_valid=1 → all outputs at reset values; fifo_level=0 after release.
- Basic ordering:
  - Stimulus: write 0x11,0x22,0x33 on consecutive cycles, ready=1, GAP=0.
  - Response: stream_out_data sequence 0x11,0x22,0x33 on consecutive cycles; first valid 1 edge after the first write; words_sent=3.
- Backpressure:
  - Stimulus: one word 0xA5 offered with ready=0 for 5 cycles, then ready=1.
  - Response: data holds 0xA5 with valid=1 throughout; stall_count=5; words_sent=1.
- Full FIFO (DEPTH=4, enable=0): write 5 words back-to-back → wr_ready drops after the 4th; 5th not accepted; fifo_level=4.
- Gap (GAP_CYCLES=2, ready=1, 3 words queued): valid pattern 1,0,0,1,0,0,1 → words_sent=3.
- Reset mid-stream:
  - Stimulus: 3 words queued, valid=1 with ready=0; pulse rst for 1 cycle.
  - Response: valid=0 next cycle; fifo_level=0; no old words emitted afterwards; counters=0.
